// File: rtl/bcd_pkg.sv
// Shared BCD definitions, also used by the 7-segment decoder blocks.
//   BCD_W       : bits per decimal digit
//   BCD_MAX/MIN : largest / smallest legal digit value
//   bcd_digit_t : one packed BCD digit
//   bcd_valid() : true when a 4-bit code is a legal decimal digit
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit register of the cascaded BCD counter.
//   clk, rst   : clock, asynchronous active-high reset (q -> 0)
//   clr        : synchronous clear (highest priority)
//   ld, ld_val : synchronous load of an already-validated digit
//   inc, dec   : step up / step down, rolling 9->0 and 0->9
//   q          : registered digit
//   is_max     : q == 9 (feeds the carry chain)
//   is_min     : q == 0 (feeds the borrow chain)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             is_max,
  output logic             is_min
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, checked parallel load,
// wrap-or-saturate limits and a combinational terminal count.
//   DIGITS   : number of decimal digits (1..8)
//   WRAP     : 1 = wrap at the limits, 0 = saturate at the limits
//   clk, rst : clock, asynchronous active-high reset
//   en, up   : count enable, direction (1 = increment)
//   clr      : synchronous clear (beats load and en)
//   load     : synchronous load of load_val (beats en)
//   load_val : load value, digit i at [4i+3:4i]
//   bcd_out  : registered count, same packing as load_val
//   tc       : terminal count, high while a wrap/saturate step is requested
//   load_err : one-cycle pulse after a load with a non-BCD digit
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] inc_vec;
  logic [DIGITS-1:0] dec_vec;
  logic              all_max;
  logic              all_min;
  logic              load_ok;
  logic              count_req;
  logic              cnt_up;
  logic              cnt_dn;
  logic              ld_go;

  // Load validation: every digit must be 0..9.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_ok = load_ok & bcd_valid(load_val[BCD_W*i +: BCD_W]);
    end
  end

  assign all_max   = &is_max;
  assign all_min   = &is_min;
  // A rejected load still blocks counting for that cycle.
  assign count_req = en & ~clr & ~load;
  assign tc        = count_req & (up ? all_max : all_min);

  // In saturate mode the step at a limit is simply suppressed.
  assign cnt_up = count_req &  up & ~(all_max & ~WRAP);
  assign cnt_dn = count_req & ~up & ~(all_min & ~WRAP);
  assign ld_go  = load & load_ok & ~clr;

  // Ripple carry/borrow: digit i steps only when all lower digits
  // are at the rollover value for the current direction.
  always_comb begin
    logic run_max;
    logic run_min;
    run_max = 1'b1;
    run_min = 1'b1;
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < DIGITS; i++) begin
      inc_vec[i] = cnt_up & run_max;
      dec_vec[i] = cnt_dn & run_min;
      run_max    = run_max & is_max[i];
      run_min    = run_min & is_min[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .ld     (ld_go),
      .ld_val (load_val[BCD_W*g +: BCD_W]),
      .inc    (inc_vec[g]),
      .dec    (dec_vec[g]),
      .q      (bcd_out[BCD_W*g +: BCD_W]),
      .is_max (is_max[g]),
      .is_min (is_min[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= ~clr & load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  localparam int D = 4;
  localparam int LIMIT = 9999;

  logic          clk = 1'b0;
  logic          rst, en, up, clr, load;
  logic [15:0]   load_val;
  logic [15:0]   bcd_w, bcd_s;
  logic          tc_w, tc_s, err_w, err_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] bw;
    logic [15:0] bs;
    logic        ew;
    logic        es;
  } exp_t;

  exp_t sb[$];
  int   mw, ms;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(D), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_w), .tc(tc_w), .load_err(err_w)
  );

  bcd_updown_counter #(.DIGITS(D), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_s), .tc(tc_s), .load_err(err_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic bit is_bcd(input logic [15:0] b);
    for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_val(input int m, input bit wrap, input logic e, input logic u,
                                  input logic c, input logic l, input logic [15:0] lv);
    if (c) return 0;
    if (l) return is_bcd(lv) ? from_bcd(lv) : m;
    if (!e) return m;
    if (u) return (m == LIMIT) ? (wrap ? 0 : LIMIT) : m + 1;
    return (m == 0) ? (wrap ? LIMIT : 0) : m - 1;
  endfunction

  // Drive one cycle of stimulus, check tc before the edge, check the
  // registered outputs after it through the scoreboard.
  task automatic step(input logic e, input logic u, input logic c, input logic l,
                      input logic [15:0] lv);
    exp_t x, y;
    logic xerr;
    en = e; up = u; clr = c; load = l; load_val = lv;
    #1;
    check("tc_wrap", tc_w, e & ~c & ~l & (u ? (mw == LIMIT) : (mw == 0)));
    check("tc_sat",  tc_s, e & ~c & ~l & (u ? (ms == LIMIT) : (ms == 0)));
    xerr = ~c & l & ~is_bcd(lv);
    mw = next_val(mw, 1'b1, e, u, c, l, lv);
    ms = next_val(ms, 1'b0, e, u, c, l, lv);
    x.bw = to_bcd(mw); x.bs = to_bcd(ms); x.ew = xerr; x.es = xerr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    check("bcd_wrap", bcd_w, y.bw);
    check("bcd_sat",  bcd_s, y.bs);
    check("err_wrap", err_w, y.ew);
    check("err_sat",  err_s, y.es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    mw = 0; ms = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd", bcd_w, 16'h0000);
    check("rst_err", err_w, 1'b0);
    check("rst_tc",  tc_w,  1'b0);
    rst = 1'b0;

    // Count up 12 times from zero.
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 16'h0000);
    check("cnt12", bcd_w, 16'h0012);

    // Carry and borrow across several digits.
    step(0, 0, 0, 1, 16'h0999);
    step(1, 1, 0, 0, 16'h0000);
    check("carry", bcd_w, 16'h1000);
    step(0, 0, 0, 1, 16'h1000);
    step(1, 0, 0, 0, 16'h0000);
    check("borrow", bcd_w, 16'h0999);

    // Upper limit: wrap vs saturate.
    step(0, 0, 0, 1, 16'h9999);
    step(1, 1, 0, 0, 16'h0000);
    check("up_wrap", bcd_w, 16'h0000);
    check("up_sat",  bcd_s, 16'h9999);

    // Lower limit: wrap vs saturate.
    step(0, 0, 1, 0, 16'h0000);
    step(1, 0, 0, 0, 16'h0000);
    check("dn_wrap", bcd_w, 16'h9999);
    check("dn_sat",  bcd_s, 16'h0000);

    // Rejected load holds the count and pulses load_err once.
    step(0, 0, 0, 1, 16'h0344);
    step(1, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 1, 16'h12A4);
    check("bad_hold", bcd_w, 16'h0345);
    check("bad_err",  err_w, 1'b1);
    step(1, 1, 0, 0, 16'h0000);
    check("err_pulse", err_w, 1'b0);
    check("after_bad", bcd_w, 16'h0346);

    // Asynchronous reset between edges while counting.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 16'h0000);
    #1 rst = 1'b1;
    #1;
    check("arst_w", bcd_w, 16'h0000);
    check("arst_s", bcd_s, 16'h0000);
    #2 rst = 1'b0;
    mw = 0; ms = 0;
    #1;
    check("arst_hold", bcd_w, 16'h0000);
    step(1, 1, 0, 0, 16'h0000);
    check("first_cnt", bcd_w, 16'h0001);

    // clr beats load and en.
    step(1, 1, 0, 1, 16'h0042);
    step(1, 1, 1, 1, 16'h5555);
    check("clr_prio", bcd_w, 16'h0000);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] lv;
      int sel;
      sel = $urandom_range(0, 19);
      lv  = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, LIMIT)) : 16'($urandom);
      if (sel == 0)      step(1, 1, 1, 0, lv);
      else if (sel < 3)  step(1, 1, 0, 1, lv);
      else if (sel == 3) step(0, 0, 0, 1, 16'h9998);
      else if (sel == 4) step(0, 0, 0, 1, 16'h0001);
      else               step($urandom_range(0, 7) != 0, sel[0], 0, 0, lv);
    end

    if (sb.size() != 0) check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter: the next generation of the team's single-digit BCD counter, generalised to N cascaded decimal digits. Adds up/down counting, synchronous clear, synchronous parallel load with BCD validity checking, wrap or saturate mode, and a terminal-count output. Used for decimal event/time counting and display-driving paths, directly feeding 7-segment decoders.

## Interface
- DIGITS, 4: number of BCD digits, legal range 1..8; the count vector is 4*DIGITS bits wide.
- WRAP, 1: 1 = wrap at the limits (9…9 → 0…0 up, 0…0 → 9…9 down); 0 = saturate at the limits.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- clr  in  1  synchronous clear to zero
- load  in  1  synchronous parallel load
- load_val  in  4*DIGITS  load value; digit i is at bits [4i+3:4i], digit 0 is least significant
- bcd_out  out  4*DIGITS  registered count, same digit packing as load_val
- tc  out  1  terminal count (combinational)
- load_err  out  1  registered one-cycle pulse on a rejected load

## Operation
- Reset, asynchronous: bcd_out = 0 and load_err = 0 immediately, independent of clk.
- Per-edge priority is clr > load > en.
- clr: bcd_out ← 0. load_err ← 0.
- load, valid: every digit of load_val is ≤ 9. bcd_out ← load_val. load_err ← 0.
- load, invalid: any digit of load_val is > 9.
  - bcd_out holds its value; no count occurs that cycle even if en = 1.
  - load_err ← 1 for one cycle.
- en with no clr and no load:
  - Up: digit 0 increments. Digit i increments only when digits 0..i-1 are all 9. A digit at 9 that increments becomes 0.
  - Down: digit 0 decrements. Digit i decrements only when digits 0..i-1 are all 0. A digit at 0 that decrements becomes 9.
- Limits:
  - At all-9 counting up: WRAP=1 → bcd_out becomes all-0. WRAP=0 → bcd_out holds all-9.
  - At all-0 counting down: WRAP=1 → bcd_out becomes all-9. WRAP=0 → bcd_out holds all-0.
- en = 0 with no clr and no load: bcd_out holds.
- load_err is 0 on every cycle except the one following a rejected load.
- tc = en & ~clr & ~load & (up ? all digits 9 : all digits 0). tc is asserted during the cycle in which the wrap or saturate event happens, in both WRAP modes.
- bcd_out never holds a non-BCD digit.

## Timing
- bcd_out and load_err have one-cycle latency from the qualifying clock edge.
- tc is purely combinational from the registered count and the current en/up/clr/load; zero latency. A cascade of counters uses tc as the next stage's en.
- A direction change takes effect on the same edge; no pipeline.
- rst asserted mid-count, including between edges: outputs go to 0 without waiting for clk. The first count occurs on the first rising edge after rst deasserts with en = 1.
- clr, load and en asserted together: clr wins and bcd_out ← 0.
- The carry chain is combinational across all digits. At DIGITS = 8, the chain is the critical path and must close at the system clock.

## Structure
- Package bcd_pkg: BCD_MAX = 4'd9, BCD_MIN = 4'd0, BCD_W = 4, and a 4-bit bcd_digit_t typedef. These are shared with the decoder blocks.
- Sub-module bcd_digit: one digit register with inputs inc, dec, ld, ld_val, clr and outputs q, is_max, is_min. Instantiate it DIGITS times with a generate loop.
- The top level builds the carry/borrow chain from is_max/is_min, performs load validation, applies WRAP/saturate gating, and generates tc and load_err.

## Test plan
(All scenarios use DIGITS = 4 and WRAP = 1 unless stated.)
- Reset, then en = 1, up = 1 for 12 edges → bcd_out = 16'h0012; tc = 0 throughout.
- load_val = 16'h0999 loaded, then one up-count → bcd_out = 16'h1000; load_val = 16'h1000 loaded, then one down-count → 16'h0999.
- Load 16'h9999, then count up → tc = 1 that cycle and bcd_out = 16'h0000 next. With WRAP = 0 → bcd_out stays 16'h9999 and tc = 1.
- From 16'h0000, count down → bcd_out = 16'h9999 and tc = 1. With WRAP = 0 → bcd_out holds 16'h0000.
- Count at 16'h0345, then load 16'h12A4 with en = 1 → bcd_out stays 16'h0345 and load_err = 1 for exactly one cycle.
- Assert rst for 3 ns between edges while counting → bcd_out = 0 before the next edge. Separately, clr = load = en = 1 with load_val = 16'h5555 → bcd_out = 16'h0000.
